// File: rtl/mux_rr_sel_if.sv
// Handshake bundle for mux_rr_sel: N producer channels in, one registered consumer channel out.
interface mux_rr_sel_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 5,
    parameter int unsigned SEL_W  = 3
);
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_valid;
    logic                    out_ready;

    // Environment side: producers, consumer and mode/select control
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    // Selector side
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/mux_rr_sel.sv
// Registered N-to-1 selector with valid/ready on every channel. Direct-select mode takes the
// channel from sel; round-robin mode searches from the channel after the last grant.
module mux_rr_sel #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 5,
    parameter int unsigned SEL_W  = 3
) (
    input logic         Clk,
    input logic         Reset,
    mux_rr_sel_if.slave bus
);
    logic [SEL_W-1:0] ptr_q;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] src_q;
    logic             valid_q;

    logic             load;
    logic             gnt_any;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;

    // Output register can take a word when empty or being drained this cycle
    assign load = !valid_q || bus.out_ready;
    assign xfer = gnt_any && load && !Reset;

    // Grant decision: depends only on valids, mode, sel and ptr, never on in_data
    always_comb begin
        int unsigned cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        if (!bus.mode) begin
            if ((32'(bus.sel) < NUM_IN) && bus.in_valid[bus.sel]) begin
                gnt_any = 1'b1;
                gnt_idx = bus.sel;
            end
        end else begin
            // ptr < NUM_IN and off <= NUM_IN, so one conditional subtract wraps the index
            for (int unsigned off = 1; off <= NUM_IN; off++) begin
                cand = 32'(ptr_q) + off;
                if (cand >= NUM_IN) begin
                    cand = cand - NUM_IN;
                end
                if (!gnt_any && bus.in_valid[cand[SEL_W-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[SEL_W-1:0];
                end
            end
        end
    end

    // Data path mux for the granted channel
    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (32'(gnt_idx) == i) begin
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept strobe: one-hot on the granted channel, forced low in reset
    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[gnt_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= SEL_W'(NUM_IN - 1);
        end else if (xfer) begin
            data_q  <= gnt_data;
            src_q   <= gnt_idx;
            valid_q <= 1'b1;
            ptr_q   <= gnt_idx;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_mux_rr_sel.sv
// Bench for mux_rr_sel: directed stimulus, a per-cycle reference model, a word scoreboard,
// and literal expectations at the points of interest.
module tb_mux_rr_sel;
    localparam int N  = 5;
    localparam int W  = 32;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux_rr_sel_if #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) bus ();

    mux_rr_sel #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    // Reference state: what the output register and last-grant index must hold
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_src   = 0;
    int           m_ptr   = N - 1;

    // Word scoreboard
    logic [W-1:0] sb[$];
    int           n_in    = 0;
    int           n_out   = 0;
    int           dropped = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] chan(input int i);
        return bus.in_data[i*W +: W];
    endfunction

    // Channel that must be granted this cycle, or -1
    function automatic int model_grant();
        if (bus.mode == 1'b0) begin
            if (int'(bus.sel) < N && bus.in_valid[bus.sel]) return int'(bus.sel);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (bus.in_valid[3'(c)]) return c;
        end
        return -1;
    endfunction

    // Every falling edge: compare DUT to the model, run the scoreboard, advance the model
    always @(negedge clk) begin
        int           g;
        int           idx;
        logic         ld;
        logic [N-1:0] er;
        g  = model_grant();
        ld = !m_valid || bus.out_ready;
        er = '0;
        if (g >= 0 && ld && !reset) er = N'(1) << g;
        check("in_ready", 64'(bus.in_ready), 64'(er));
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        check("out_data", 64'(bus.out_data), 64'(m_data));
        check("out_src", 64'(bus.out_src), 64'(m_src));

        if (reset) begin
            dropped += sb.size();
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) check("sb_data", 64'(bus.out_data), 64'(sb.pop_front()));
                n_out++;
            end
            if ((bus.in_valid & bus.in_ready) != '0) begin
                idx = 0;
                for (int i = 0; i < N; i++) begin
                    if (bus.in_valid[3'(i)] && bus.in_ready[3'(i)]) idx = i;
                end
                sb.push_back(chan(idx));
                n_in++;
            end
        end

        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= 0;
            m_ptr   <= N - 1;
        end else if (er != '0) begin
            m_valid <= 1'b1;
            m_data  <= chan(g);
            m_src   <= g;
            m_ptr   <= g;
        end else if (m_valid && bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.mode      = 1'b1;
        bus.sel       = '0;
        bus.in_valid  = '1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 32'(i * 16);

        // Reset held two cycles with everything valid
        repeat (2) tick();
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_data", 64'(bus.out_data), 64'(0));
        check("rst_src", 64'(bus.out_src), 64'(0));
        check("rst_ready", 64'(bus.in_ready), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("first_rr_ready", 64'(bus.in_ready), 64'(5'b00001));
        tick();
        check("first_rr_src", 64'(bus.out_src), 64'(0));
        check("first_rr_valid", 64'(bus.out_valid), 64'(1));

        // Direct select sweep
        bus.mode = 1'b0;
        for (int s = 0; s < N; s++) begin
            bus.sel = 3'(s);
            @(negedge clk);
            check("dir_ready", 64'(bus.in_ready), 64'(1 << s));
            tick();
            check("dir_data", 64'(bus.out_data), 64'(s * 16));
            check("dir_src", 64'(bus.out_src), 64'(s));
        end
        for (int s = N; s < 8; s++) begin
            bus.sel = 3'(s);
            @(negedge clk);
            check("oor_ready", 64'(bus.in_ready), 64'(0));
            tick();
            check("oor_valid", 64'(bus.out_valid), 64'(0));
        end

        // Round-robin fairness: last grant was 4, so 0..4 twice
        bus.mode = 1'b1;
        for (int k = 0; k < 2 * N; k++) begin
            tick();
            check("rr_src", 64'(bus.out_src), 64'(k % N));
            check("rr_data", 64'(bus.out_data), 64'((k % N) * 16));
        end

        // Sparse round-robin from ptr=3
        bus.in_valid = 5'b01010;
        bus.mode     = 1'b0;
        bus.sel      = 3'd3;
        tick();
        check("sparse_seed", 64'(bus.out_src), 64'(3));
        bus.mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("sparse_src", 64'(bus.out_src), 64'((k % 2 == 0) ? 1 : 3));
        end
        bus.in_valid = 5'b01000;
        repeat (2) begin
            tick();
            check("sparse_only3", 64'(bus.out_src), 64'(3));
        end

        // Backpressure for three cycles
        bus.in_valid  = '1;
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready", 64'(bus.in_ready), 64'(0));
            tick();
            check("bp_valid", 64'(bus.out_valid), 64'(1));
            check("bp_src", 64'(bus.out_src), 64'(3));
            check("bp_data", 64'(bus.out_data), 64'(32'h30));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(bus.in_ready), 64'(5'b10000));
        tick();
        check("bp_release_src", 64'(bus.out_src), 64'(4));
        check("bp_release_data", 64'(bus.out_data), 64'(32'h40));

        // Mode switch continues from the direct-mode grant
        bus.mode = 1'b0;
        bus.sel  = 3'd2;
        tick();
        check("ms_direct_src", 64'(bus.out_src), 64'(2));
        bus.mode = 1'b1;
        tick();
        check("ms_rr_src", 64'(bus.out_src), 64'(3));

        // Reset mid-stream discards the word and rewinds the pointer
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 64'(bus.in_ready), 64'(0));
        tick();
        check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_src", 64'(bus.out_src), 64'(0));
        reset = 1'b0;
        tick();
        check("post_rst_src", 64'(bus.out_src), 64'(0));

        // Drain and confirm conservation of words
        bus.in_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        check("drain_valid", 64'(bus.out_valid), 64'(0));
        check("sb_empty", 64'(sb.size()), 64'(0));
        check("words_conserved", 64'(n_in), 64'(n_out + dropped));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
